mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter that lets the CPU's instruction-fetch port and data port share a single synchronous memory. It sits between `mycpu` and a unified memory, accepting one request at a time from either side, sequencing the memory access and returning a one-cycle acknowledge with read data. Simultaneous requests are resolved round-robin so neither port starves.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_rr2.sv | 22 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   // Wide enough for a latency count up to 4
   localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the port not granted last time wins.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_d,
   output logic gnt_id_c,
   output logic gnt_vld_c
);

   always_comb begin
      gnt_vld_c = i_req | d_req;
      gnt_id_c  = PORT_I;
      if (i_req && d_req) begin
         gnt_id_c = last_d ? PORT_I : PORT_D;
      end else if (d_req) begin
         gnt_id_c = PORT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between the instruction-fetch and data ports,
// one access at a time, with a one-cycle acknowledge per completed access.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gnt_q, gnt_d;
   logic             last_d_q, last_d_d;
   logic             gnt_id_c, gnt_vld_c;

   logic             m_en_d, m_we_d, i_ack_d, d_ack_d, busy_d;
   logic [AW-1:0]    m_addr_d;
   logic [DW-1:0]    m_wdata_d, i_rdata_d, d_rdata_d;

   arb_rr2 u_arb (
      .i_req     (i_req),
      .d_req     (d_req),
      .last_d    (last_d_q),
      .gnt_id_c  (gnt_id_c),
      .gnt_vld_c (gnt_vld_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gnt_q    <= PORT_I;
         last_d_q <= 1'b0;
         m_en     <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         i_ack    <= 1'b0;
         d_ack    <= 1'b0;
         i_rdata  <= '0;
         d_rdata  <= '0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         last_d_q <= last_d_d;
         m_en     <= m_en_d;
         m_we     <= m_we_d;
         m_addr   <= m_addr_d;
         m_wdata  <= m_wdata_d;
         i_ack    <= i_ack_d;
         d_ack    <= d_ack_d;
         i_rdata  <= i_rdata_d;
         d_rdata  <= d_rdata_d;
         busy     <= busy_d;
      end
   end

   // Next state and registered outputs; m_addr/m_wdata double as the latched request
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      last_d_d  = last_d_q;
      m_en_d    = 1'b0;
      m_we_d    = 1'b0;
      m_addr_d  = m_addr;
      m_wdata_d = m_wdata;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      i_rdata_d = i_rdata;
      d_rdata_d = d_rdata;

      unique case (state_q)
         ST_IDLE: begin
            if (gnt_vld_c) begin
               gnt_d     = gnt_id_c;
               last_d_d  = gnt_id_c;
               m_en_d    = 1'b1;
               state_d   = ST_ISSUE;
               if (gnt_id_c == PORT_D) begin
                  m_we_d    = d_we;
                  m_addr_d  = d_addr;
                  m_wdata_d = d_wdata;
               end else begin
                  m_we_d    = 1'b0;
                  m_addr_d  = i_addr;
                  m_wdata_d = '0;
               end
            end
         end
         ST_ISSUE: begin
            if (m_we) begin
               d_ack_d = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d   = CNT_W'(1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(MEM_LAT)) begin
               state_d = ST_RESP;
               if (gnt_q == PORT_D) begin
                  d_rdata_d = m_rdata;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = m_rdata;
                  i_ack_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=1 instance against a small memory
// model, plus four instances (MEM_LAT 1..4) fed a cycle-stamped read bus.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic        i_ack, d_ack, m_en, m_we, busy;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_ack   (i_ack),
      .i_rdata (i_rdata),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_ack   (d_ack),
      .d_rdata (d_rdata),
      .m_en    (m_en),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .busy    (busy)
   );

   // One-cycle-latency memory; address 0x40 holds a fixed instruction word
   logic [31:0] mem [64];
   logic [31:0] rd_q = 32'h0;
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr[7:2]] <= m_wdata;
         else      rd_q <= (m_addr == 32'h40) ? 32'h2008000A : mem[m_addr[7:2]];
      end
   end
   assign m_rdata = rd_q;

   // Latency sweep: m_rdata carries the current cycle number
   logic        sw_req;
   logic [31:0] sw_addr;
   logic [3:0]  sw_ack;
   logic [31:0] sw_rdata [4];

   for (genvar g = 0; g < 4; g++) begin : g_sw
      logic        da, men, mwe, bsy;
      logic [31:0] drd, maddr, mwdata, mrd;
      assign mrd = 32'hA000_0000 | (32'(g) << 16) | 32'(cyc);
      mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(g + 1)) u_sw (
         .clk     (clk),
         .rst     (rst),
         .i_req   (sw_req),
         .i_addr  (sw_addr),
         .i_ack   (sw_ack[g]),
         .i_rdata (sw_rdata[g]),
         .d_req   (1'b0),
         .d_we    (1'b0),
         .d_addr  (32'h0),
         .d_wdata (32'h0),
         .d_ack   (da),
         .d_rdata (drd),
         .m_en    (men),
         .m_we    (mwe),
         .m_addr  (maddr),
         .m_wdata (mwdata),
         .m_rdata (mrd),
         .busy    (bsy)
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int nacks;
      logic prev_ack;
      int t;
      int ack_cyc [4];
      logic [31:0] ack_dat [4];

      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; sw_req = 1'b0; sw_addr = '0;
      repeat (2) tick();
      check("rst_m_en",    32'(m_en), 0);
      check("rst_busy",    32'(busy), 0);
      check("rst_acks",    32'({i_ack, d_ack}), 0);
      check("rst_m_addr",  m_addr, 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      rst = 1'b1;
      tick();

      // Single instruction read
      i_req = 1'b1; i_addr = 32'h40;
      tick();
      check("rd_m_en",   32'(m_en), 1);
      check("rd_m_addr", m_addr, 32'h40);
      check("rd_m_we",   32'(m_we), 0);
      check("rd_busy",   32'(busy), 1);
      tick();
      check("rd_ack_early", 32'(i_ack), 0);
      tick();
      check("rd_i_ack",   32'(i_ack), 1);
      check("rd_i_rdata", i_rdata, 32'h2008000A);
      check("rd_d_ack",   32'(d_ack), 0);
      i_req = 1'b0;
      tick();
      check("rd_idle_busy", 32'(busy), 0);

      // Data write then read back
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h7;
      tick();
      check("wr_m_en",    32'(m_en), 1);
      check("wr_m_we",    32'(m_we), 1);
      check("wr_m_addr",  m_addr, 32'h54);
      check("wr_m_wdata", m_wdata, 32'h7);
      tick();
      check("wr_d_ack",   32'(d_ack), 1);
      check("wr_d_rdata", d_rdata, 0);
      d_req = 1'b0; d_we = 1'b0;
      tick();
      d_req = 1'b1;
      repeat (3) tick();
      check("rb_d_ack",   32'(d_ack), 1);
      check("rb_d_rdata", d_rdata, 32'h7);
      check("rb_i_rdata", i_rdata, 32'h2008000A);
      d_req = 1'b0;
      tick();

      // Reset during WAIT of a data read
      d_req = 1'b1;
      tick();
      tick();
      check("rw_busy_wait", 32'(busy), 1);
      rst = 1'b0;
      #1;
      check("rw_busy",    32'(busy), 0);
      check("rw_acks",    32'({i_ack, d_ack}), 0);
      check("rw_m_en",    32'(m_en), 0);
      check("rw_d_rdata", d_rdata, 0);
      check("rw_i_rdata", i_rdata, 0);
      i_req = 1'b1; i_addr = 32'h40;
      tick();
      check("rw_no_ack", 32'(d_ack), 0);
      rst = 1'b1;

      // Contention from reset: D, I, D, I
      nacks = 0; prev_ack = 1'b0;
      for (int k = 0; k < 60 && nacks < 4; k++) begin
         tick();
         if (i_ack || d_ack) begin
            check("ct_excl",  32'(i_ack & d_ack), 0);
            check("ct_gap",   32'(prev_ack), 0);
            check("ct_order", 32'(d_ack), (nacks % 2 == 0) ? 32'd1 : 32'd0);
            if (d_ack) check("ct_d_rdata", d_rdata, 32'h7);
            else       check("ct_i_rdata", i_rdata, 32'h2008000A);
            nacks++;
         end
         prev_ack = i_ack | d_ack;
      end
      check("ct_count", 32'(nacks), 4);
      i_req = 1'b0; d_req = 1'b0;
      tick();

      // Instruction request dropped in ISSUE, data request raised meanwhile
      i_req = 1'b1; i_addr = 32'h40;
      tick();
      i_req = 1'b0; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h54;
      tick();
      check("dr_ack_early", 32'(i_ack), 0);
      tick();
      check("dr_i_ack",   32'(i_ack), 1);
      check("dr_i_rdata", i_rdata, 32'h2008000A);
      tick();
      check("dr_idle", 32'(busy), 0);
      tick();
      check("dr_d_m_en",   32'(m_en), 1);
      check("dr_d_m_addr", m_addr, 32'h54);
      repeat (2) tick();
      check("dr_d_ack",   32'(d_ack), 1);
      check("dr_d_rdata", d_rdata, 32'h7);
      d_req = 1'b0;
      tick();

      // Latency sweep over MEM_LAT 1..4
      for (int g = 0; g < 4; g++) begin
         ack_cyc[g] = -1;
         ack_dat[g] = '0;
      end
      t = cyc;
      sw_req = 1'b1; sw_addr = 32'h100;
      tick();
      sw_req = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         for (int g = 0; g < 4; g++) begin
            if (sw_ack[g] && ack_cyc[g] < 0) begin
               ack_cyc[g] = cyc;
               ack_dat[g] = sw_rdata[g];
            end
         end
      end
      for (int g = 0; g < 4; g++) begin
         check($sformatf("sw_lat%0d_cyc", g + 1), 32'(ack_cyc[g] - t), 32'(g + 3));
         check($sformatf("sw_lat%0d_dat", g + 1), ack_dat[g],
               32'hA000_0000 | (32'(g) << 16) | 32'(t + 2 + g));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
